// File: rtl/cache_pkg.sv
// Shared encodings for the cache refill read-path arbiter.
package cache_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ADDR = ST_ADDR,
        S_DATA = ST_DATA
    } state_t;

endpackage

// File: rtl/cache_axi_rd_arbiter_if.sv
// Cache refill request/return ports plus the shared AXI AR/R channel.
// master = arbiter side, slave = caches + AXI fabric side.
interface cache_axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              ic_rd_req;
    logic [ADDR_W-1:0] ic_rd_addr;
    logic [LEN_W-1:0]  ic_rd_len;
    logic              ic_rd_gnt;
    logic              ic_ret_valid;
    logic              ic_ret_last;
    logic [LEN_W-1:0]  ic_ret_idx;
    logic [DATA_W-1:0] ic_ret_data;

    logic              dc_rd_req;
    logic [ADDR_W-1:0] dc_rd_addr;
    logic [LEN_W-1:0]  dc_rd_len;
    logic              dc_rd_gnt;
    logic              dc_ret_valid;
    logic              dc_ret_last;
    logic [LEN_W-1:0]  dc_ret_idx;
    logic [DATA_W-1:0] dc_ret_data;

    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic              RVALID;
    logic              RLAST;
    logic              RREADY;

    modport master (
        input  ic_rd_req, ic_rd_addr, ic_rd_len,
        output ic_rd_gnt, ic_ret_valid, ic_ret_last, ic_ret_idx, ic_ret_data,
        input  dc_rd_req, dc_rd_addr, dc_rd_len,
        output dc_rd_gnt, dc_ret_valid, dc_ret_last, dc_ret_idx, dc_ret_data,
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  ARREADY, RDATA, RVALID, RLAST
    );

    modport slave (
        output ic_rd_req, ic_rd_addr, ic_rd_len,
        input  ic_rd_gnt, ic_ret_valid, ic_ret_last, ic_ret_idx, ic_ret_data,
        output dc_rd_req, dc_rd_addr, dc_rd_len,
        input  dc_rd_gnt, dc_ret_valid, dc_ret_last, dc_ret_idx, dc_ret_data,
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output ARREADY, RDATA, RVALID, RLAST
    );

endinterface

// File: rtl/cache_axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick; ptr selects the favoured requester on a tie.
// Latency: combinational. Backpressure: none, caller decides when to sample.
module rr_arb2
    import cache_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       win_id
);

    always_comb begin
        gnt    = 2'b00;
        win_id = REQ_IC;
        if (req[0] && (!req[1] || ptr == REQ_IC)) begin
            gnt    = 2'b01;
            win_id = REQ_IC;
        end else if (req[1]) begin
            gnt    = 2'b10;
            win_id = REQ_DC;
        end
    end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI read channel between I-cache and D-cache refills, one burst at a time.
// Latency: request in cycle N gives ARVALID in N+1. Backpressure: ARREADY stalls ADDR; R is never stalled.
module cache_axi_rd_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    cache_axi_rd_arbiter_if.master bus
);

    state_t            state;
    state_t            state_n;
    logic              rr_ptr;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [1:0]        arb_gnt;
    logic              arb_id;

    rr_arb2 u_arb (
        .req    ({bus.dc_rd_req, bus.ic_rd_req}),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .win_id (arb_id)
    );

    assign bus.ARADDR = addr_q;
    assign bus.ARLEN  = len_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n          = state;
        bus.ARVALID      = 1'b0;
        bus.RREADY       = 1'b0;
        bus.ic_rd_gnt    = 1'b0;
        bus.dc_rd_gnt    = 1'b0;
        bus.ic_ret_valid = 1'b0;
        bus.ic_ret_last  = 1'b0;
        bus.ic_ret_idx   = '0;
        bus.ic_ret_data  = {DATA_W{1'b0}};
        bus.dc_ret_valid = 1'b0;
        bus.dc_ret_last  = 1'b0;
        bus.dc_ret_idx   = '0;
        bus.dc_ret_data  = {DATA_W{1'b0}};
        case (state)
            S_IDLE: begin
                if (|arb_gnt) state_n = S_ADDR;
            end
            S_ADDR: begin
                // ARVALID depends on state only, never on ARREADY.
                bus.ARVALID = 1'b1;
                if (bus.ARREADY) begin
                    bus.ic_rd_gnt = (owner == REQ_IC);
                    bus.dc_rd_gnt = (owner == REQ_DC);
                    state_n       = S_DATA;
                end
            end
            S_DATA: begin
                bus.RREADY = 1'b1;
                if (owner == REQ_IC) begin
                    bus.ic_ret_valid = bus.RVALID;
                    bus.ic_ret_last  = bus.RLAST;
                    bus.ic_ret_idx   = beat_cnt;
                    bus.ic_ret_data  = bus.RDATA;
                end else begin
                    bus.dc_ret_valid = bus.RVALID;
                    bus.dc_ret_last  = bus.RLAST;
                    bus.dc_ret_idx   = beat_cnt;
                    bus.dc_ret_data  = bus.RDATA;
                end
                if (bus.RVALID && bus.RLAST) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr   <= REQ_IC;
            owner    <= REQ_IC;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|arb_gnt) begin
                        owner  <= arb_id;
                        addr_q <= (arb_id == REQ_DC) ? bus.dc_rd_addr : bus.ic_rd_addr;
                        len_q  <= (arb_id == REQ_DC) ? bus.dc_rd_len  : bus.ic_rd_len;
                    end
                end
                S_ADDR: begin
                    if (bus.ARREADY) beat_cnt <= '0;
                end
                S_DATA: begin
                    // Burst length is trusted to RLAST; the counter just wraps.
                    if (bus.RVALID) beat_cnt <= beat_cnt + LEN_W'(1);
                    if (bus.RVALID && bus.RLAST) rr_ptr <= ~owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Randomised bench for cache_axi_rd_arbiter against a rule-level model of arbitration and beat return.
module tb_cache_axi_rd_arbiter;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;
    bit   exp_ptr;

    cache_axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();

    cache_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_inputs();
        bus.ic_rd_req  = 1'b0;
        bus.ic_rd_addr = '0;
        bus.ic_rd_len  = '0;
        bus.dc_rd_req  = 1'b0;
        bus.dc_rd_addr = '0;
        bus.dc_rd_len  = '0;
        bus.ARREADY    = 1'b0;
        bus.RDATA      = '0;
        bus.RVALID     = 1'b0;
        bus.RLAST      = 1'b0;
    endtask

    task automatic apply_reset();
        logic [95:0] outs;
        @(negedge clk);
        resetn = 1'b0;
        bus.ic_rd_req = 1'b1;
        bus.dc_rd_req = 1'b1;
        bus.RVALID    = 1'b1;
        bus.RLAST     = 1'b1;
        bus.ARREADY   = 1'b1;
        @(negedge clk);
        #1;
        outs = {bus.ARVALID, bus.RREADY, bus.ic_rd_gnt, bus.dc_rd_gnt,
                bus.ic_ret_valid, bus.ic_ret_last, bus.dc_ret_valid, bus.dc_ret_last,
                bus.ARADDR, bus.ARLEN, bus.ic_ret_idx, bus.dc_ret_idx, bus.ic_ret_data[15:0]};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected 0", outs);
        end
        n_checks++;
        if ({bus.ic_ret_data, bus.dc_ret_data} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {bus.ic_ret_data, bus.dc_ret_data});
        end
        clear_inputs();
        resetn  = 1'b1;
        exp_ptr = 1'b0;
    endtask

    // One complete request -> AR -> R burst; gap_mode 0 none, 1 delays beats 1 and 3 by two cycles,
    // 2 random gaps. rst_beat >= 0 pulls resetn low on that beat and abandons the burst.
    task automatic do_burst(input bit icq, input bit dcq, input logic [31:0] ia, input logic [31:0] da,
                            input logic [7:0] il, input logic [7:0] dl, input int stall,
                            input int gap_mode, input int rst_beat);
        bit          w;
        logic [31:0] ea;
        logic [7:0]  el;
        int          nb;
        int          ng;
        logic [41:0] own_ret;
        logic [41:0] oth_ret;
        logic [41:0] exp_ret;

        w  = (icq && dcq) ? exp_ptr : dcq;
        ea = w ? da : ia;
        el = w ? dl : il;
        nb = int'(el) + 1;

        @(negedge clk);
        bus.ic_rd_req = icq;  bus.ic_rd_addr = ia;  bus.ic_rd_len = il;
        bus.dc_rd_req = dcq;  bus.dc_rd_addr = da;  bus.dc_rd_len = dl;
        bus.ARREADY = 1'b0;   bus.RVALID = 1'b0;    bus.RLAST = 1'b0;
        #1;
        n_checks++;
        if ({bus.ARVALID, bus.RREADY, bus.ic_rd_gnt, bus.dc_rd_gnt, bus.ic_ret_valid, bus.dc_ret_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL idle_out: got %b expected 000000",
                     {bus.ARVALID, bus.RREADY, bus.ic_rd_gnt, bus.dc_rd_gnt, bus.ic_ret_valid, bus.dc_ret_valid});
        end

        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            bus.ARREADY    = (k == stall);
            bus.RVALID     = 1'(k != stall) & 1'($urandom);
            bus.RLAST      = 1'($urandom);
            bus.RDATA      = $urandom;
            bus.ic_rd_addr = $urandom;
            bus.dc_rd_addr = $urandom;
            bus.ic_rd_len  = 8'($urandom);
            bus.dc_rd_len  = 8'($urandom);
            #1;
            n_checks++;
            if ({bus.ARVALID, bus.ARADDR, bus.ARLEN, bus.RREADY, bus.ic_ret_valid, bus.dc_ret_valid}
                    !== {1'b1, ea, el, 3'b000}) begin
                n_fail++;
                $display("FAIL addr_phase: got v=%b a=%h l=%h rr=%b rv=%b%b expected v=1 a=%h l=%h rr=0 rv=00",
                         bus.ARVALID, bus.ARADDR, bus.ARLEN, bus.RREADY, bus.ic_ret_valid, bus.dc_ret_valid, ea, el);
            end
            n_checks++;
            if ({bus.ic_rd_gnt, bus.dc_rd_gnt} !== ((k == stall) ? (w ? 2'b01 : 2'b10) : 2'b00)) begin
                n_fail++;
                $display("FAIL grant: got ic=%b dc=%b expected %b (stall cycle %0d of %0d)",
                         bus.ic_rd_gnt, bus.dc_rd_gnt, (k == stall) ? (w ? 2'b01 : 2'b10) : 2'b00, k, stall);
            end
        end

        for (int idx = 0; idx < nb; idx++) begin
            ng = 0;
            if (gap_mode == 1 && (idx == 1 || idx == 3)) ng = 2;
            if (gap_mode == 2) ng = int'($urandom_range(0, 2));
            for (int g = 0; g <= ng; g++) begin
                @(negedge clk);
                bus.ARREADY = 1'($urandom);
                bus.RDATA   = $urandom;
                bus.RVALID  = (g == ng);
                bus.RLAST   = (g == ng) ? (idx == nb - 1) : 1'($urandom);
                if (g == ng && idx == rst_beat) begin
                    resetn = 1'b0;
                    @(negedge clk);
                    #1;
                    n_checks++;
                    if ({bus.ARVALID, bus.RREADY, bus.ic_rd_gnt, bus.dc_rd_gnt, bus.ic_ret_valid,
                         bus.ic_ret_last, bus.dc_ret_valid, bus.dc_ret_last, bus.ic_ret_idx, bus.dc_ret_idx,
                         bus.ARADDR, bus.ARLEN} !== '0) begin
                        n_fail++;
                        $display("FAIL midburst_reset: got arv=%b rr=%b gnt=%b%b rv=%b%b araddr=%h expected all 0",
                                 bus.ARVALID, bus.RREADY, bus.ic_rd_gnt, bus.dc_rd_gnt,
                                 bus.ic_ret_valid, bus.dc_ret_valid, bus.ARADDR);
                    end
                    clear_inputs();
                    resetn  = 1'b1;
                    exp_ptr = 1'b0;
                    return;
                end
                #1;
                own_ret = w ? {bus.dc_ret_valid, bus.dc_ret_last, bus.dc_ret_idx, bus.dc_ret_data}
                            : {bus.ic_ret_valid, bus.ic_ret_last, bus.ic_ret_idx, bus.ic_ret_data};
                oth_ret = w ? {bus.ic_ret_valid, bus.ic_ret_last, bus.ic_ret_idx, bus.ic_ret_data}
                            : {bus.dc_ret_valid, bus.dc_ret_last, bus.dc_ret_idx, bus.dc_ret_data};
                exp_ret = {bus.RVALID, bus.RLAST, 8'(idx), bus.RDATA};
                n_checks++;
                if (own_ret !== exp_ret || bus.RREADY !== 1'b1 || bus.ARVALID !== 1'b0) begin
                    n_fail++;
                    $display("FAIL beat: owner=%0d got %h rready=%b arvalid=%b expected %h rready=1 arvalid=0",
                             w, own_ret, bus.RREADY, bus.ARVALID, exp_ret);
                end
                n_checks++;
                if (oth_ret !== 42'd0 || {bus.ic_rd_gnt, bus.dc_rd_gnt} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL nonowner: got %h gnt=%b%b expected 0", oth_ret, bus.ic_rd_gnt, bus.dc_rd_gnt);
                end
            end
        end
        exp_ptr = ~w;

        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if ({bus.ARVALID, bus.RREADY, bus.ic_ret_valid, bus.dc_ret_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_burst: got arv=%b rr=%b rv=%b%b expected 0000",
                     bus.ARVALID, bus.RREADY, bus.ic_ret_valid, bus.dc_ret_valid);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_ic_only();
        do_burst(1'b1, 1'b0, 32'h1000, 32'h0, 8'd3, 8'd0, 0, 0, -1);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        do_burst(1'b1, 1'b1, 32'h2000, 32'h8000, 8'd1, 8'd2, 0, 0, -1);
        do_burst(1'b1, 1'b1, 32'h2040, 32'h8040, 8'd2, 8'd1, 1, 0, -1);
        do_burst(1'b1, 1'b1, 32'h2080, 32'h8080, 8'd0, 8'd3, 0, 0, -1);
    endtask

    task automatic test_ar_stall();
        do_burst(1'b0, 1'b1, 32'h0, 32'hCAFE_0000, 8'd0, 8'd2, 5, 0, -1);
    endtask

    task automatic test_rvalid_gaps();
        do_burst(1'b1, 1'b0, 32'h3000, 32'h0, 8'd3, 8'd0, 0, 1, -1);
    endtask

    task automatic test_reset_mid_burst();
        do_burst(1'b1, 1'b0, 32'h4000, 32'h0, 8'd1, 8'd0, 0, 0, -1);
        do_burst(1'b1, 1'b1, 32'h4100, 32'h5100, 8'd3, 8'd3, 0, 0, 2);
        do_burst(1'b1, 1'b1, 32'h4200, 32'h5200, 8'd1, 8'd1, 0, 0, -1);
    endtask

    task automatic test_single_beat();
        do_burst(1'b0, 1'b1, 32'h0, 32'h6000, 8'd0, 8'd0, 0, 0, -1);
        do_burst(1'b1, 1'b0, 32'h6100, 32'h0, 8'd0, 8'd0, 2, 0, -1);
    endtask

    task automatic test_random();
        bit icq;
        bit dcq;
        for (int n = 0; n < 16; n++) begin
            icq = 1'($urandom);
            dcq = icq ? 1'($urandom) : 1'b1;
            do_burst(icq, dcq, $urandom, $urandom, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), 2, -1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_ptr  = 1'b0;
        resetn   = 1'b0;
        clear_inputs();
        test_reset();
        test_ic_only();
        test_simultaneous();
        test_ar_stall();
        test_rvalid_gaps();
        test_reset_mid_burst();
        test_single_beat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
